// File: rtl/pipe_elastic_pkg.sv
// Shared definitions for the elastic (valid/ready) delay pipe.
//   SKID_ENTRIES   entries per stage: main register plus one skid register
//   stage_act_e    the single state update a stage performs on a clock edge
//   stage_action() picks that update from flush, occupancy and handshakes
//   PIPE_ELASTIC_SLOT_T(W) builds a {valid, data} slot of payload width W

`ifndef PIPE_ELASTIC_PKG_SV
`define PIPE_ELASTIC_PKG_SV

`define PIPE_ELASTIC_SLOT_T(W) struct packed { logic v; logic [(W)-1:0] d; }

package pipe_elastic_pkg;

   localparam int SKID_ENTRIES = 2;

   // Slot index within a stage.
   localparam int MAIN = 0;
   localparam int SKID = 1;

   typedef enum logic [2:0] {
      ACT_HOLD,          // nothing moves
      ACT_FLUSH,         // drop everything held
      ACT_SKID_TO_MAIN,  // main leaves, skid refills it
      ACT_LOAD_MAIN,     // main takes the incoming word
      ACT_DRAIN,         // main leaves, nothing replaces it
      ACT_LOAD_SKID      // main is stuck, park the incoming word
   } stage_act_e;

   // A stage with a full skid has in_ready low, so accept and a full skid
   // never occur together; the order below relies on that.
   function automatic stage_act_e stage_action(input logic flush,
                                               input logic main_v,
                                               input logic skid_v,
                                               input logic accept,
                                               input logic emit);
      if (flush)               return ACT_FLUSH;
      if (emit && skid_v)      return ACT_SKID_TO_MAIN;
      if (emit && accept)      return ACT_LOAD_MAIN;
      if (emit)                return ACT_DRAIN;
      if (accept && !main_v)   return ACT_LOAD_MAIN;
      if (accept)              return ACT_LOAD_SKID;
      return ACT_HOLD;
   endfunction

endpackage

`endif

// File: rtl/pipe_elastic_skid.sv
// One registered skid stage of the elastic pipe.
//   clk, rst             clock, asynchronous active-low reset
//   flush                synchronous clear of both entries; blocks input
//   in_valid/in_ready    upstream handshake; in_ready comes from the skid flop
//   in_data              payload in
//   out_valid/out_ready  downstream handshake
//   out_data             payload out, taken straight from the main register

module pipe_elastic_skid
   import pipe_elastic_pkg::*;
#(
   parameter int DATAW = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DATAW-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DATAW-1:0] out_data
);

   typedef `PIPE_ELASTIC_SLOT_T(DATAW) slot_t;

   slot_t      slot_q [SKID_ENTRIES];
   slot_t      slot_d [SKID_ENTRIES];
   logic       accept;
   logic       emit;
   stage_act_e act;

   // Ready depends only on our own skid flop, so out_ready never ripples
   // combinationally back to the producer.
   assign in_ready  = !slot_q[SKID].v && !flush;
   assign out_valid = slot_q[MAIN].v;
   assign out_data  = slot_q[MAIN].d;

   assign accept = in_valid && in_ready;
   assign emit   = slot_q[MAIN].v && out_ready;
   assign act    = stage_action(flush, slot_q[MAIN].v, slot_q[SKID].v, accept, emit);

   always_comb begin
      // NOTE: next state starts as a copy of the current state so every
      // path assigns it; a missing default here would infer latches.
      slot_d = slot_q;
      case (act)
         ACT_FLUSH: begin
            // Data is left in place; only the valid flags matter after a flush.
            slot_d[MAIN].v = 1'b0;
            slot_d[SKID].v = 1'b0;
         end
         ACT_SKID_TO_MAIN: begin
            slot_d[MAIN]   = slot_q[SKID];
            slot_d[SKID].v = 1'b0;
         end
         ACT_LOAD_MAIN: slot_d[MAIN] = '{v: 1'b1, d: in_data};
         ACT_DRAIN:     slot_d[MAIN].v = 1'b0;
         ACT_LOAD_SKID: slot_d[SKID] = '{v: 1'b1, d: in_data};
         default:       ;
      endcase
   end

   // NOTE: the data registers are reset as well as the valid flags, because
   // out_data must read 0 during and straight after reset; sequential state
   // is written with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SKID_ENTRIES; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         slot_q <= slot_d;
      end
   end

endmodule

// File: rtl/pipe_elastic.sv
// Elastic delay pipe: DEPTH skid stages under a valid/ready handshake.
// Backpressure from out_ready reaches in_ready one stage per cycle; the pipe
// holds up to 2*DEPTH words. DEPTH=0 is a pure combinational passthrough.
//   clk, rst             clock, asynchronous active-low reset
//   flush                synchronous clear of every stage; blocks input
//   in_valid/in_ready    producer handshake
//   in_data              payload in
//   out_valid/out_ready  consumer handshake
//   out_data             payload out

module pipe_elastic
   import pipe_elastic_pkg::*;
#(
   parameter int DATAW = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DATAW-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DATAW-1:0] out_data
);

   if (DEPTH == 0) begin : g_pass
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign in_ready  = out_ready && !flush;
   end else begin : g_chain
      // Link i connects stage i-1 to stage i; link 0 is the block input and
      // link DEPTH is the block output.
      logic [DEPTH:0]   link_v;
      logic [DEPTH:0]   link_r;
      logic [DATAW-1:0] link_d [DEPTH+1];

      assign link_v[0]     = in_valid;
      assign link_d[0]     = in_data;
      assign in_ready      = link_r[0];
      assign out_valid     = link_v[DEPTH];
      assign out_data      = link_d[DEPTH];
      assign link_r[DEPTH] = out_ready;

      for (genvar i = 0; i < DEPTH; i++) begin : g_stage
         pipe_elastic_skid #(
            .DATAW (DATAW)
         ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (link_v[i]),
            .in_ready  (link_r[i]),
            .in_data   (link_d[i]),
            .out_valid (link_v[i+1]),
            .out_ready (link_r[i+1]),
            .out_data  (link_d[i+1])
         );
      end
   end

endmodule
